// File: rtl/execute_stage_mdu_if.sv
// Issue/result handshake bundle for execute_stage_mdu.
// The master side drives the issue fields and out_ready; the slave side is the stage itself.
interface execute_stage_mdu_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Read1;
  logic [DATA_W-1:0] Read2;
  logic [4:0]        ALUop;
  logic              MovEn;
  logic              Movz;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              RegWrite_in;
  logic              RegDst;
  logic              regAddr_jal;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ALU_out;
  logic [REG_AW-1:0] WriteRegister_out;
  logic              RegWrite_out;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;
  logic              mdu_busy;

  modport master (
    output in_valid, Read1, Read2, ALUop, MovEn, Movz, rt, rd,
           RegWrite_in, RegDst, regAddr_jal, out_ready,
    input  in_ready, out_valid, ALU_out, WriteRegister_out, RegWrite_out,
           HI, LO, mdu_busy
  );

  modport slave (
    input  in_valid, Read1, Read2, ALUop, MovEn, Movz, rt, rd,
           RegWrite_in, RegDst, regAddr_jal, out_ready,
    output in_ready, out_valid, ALU_out, WriteRegister_out, RegWrite_out,
           HI, LO, mdu_busy
  );
endinterface

// File: rtl/execute_stage_mdu.sv
// Registered MIPS EX stage: ALU, MOVZ/MOVN, destination select, HI/LO and an iterative MDU.
// Optional FAST_MULT_EN: single-cycle MULT/MULTU (only the FIX cycle is spent busy).
module execute_stage_mdu #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input logic                Clk,
  input logic                Rst,
  execute_stage_mdu_if.slave bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic [DATA_W-1:0] mag_f(input logic [DATA_W-1:0] v, input logic sgn);
    mag_f = (sgn && v[DATA_W-1]) ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0]   opa_q, opa_d, dvd_q, dvd_d;
  logic                neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic                divz_q, divz_d, is_div_q, is_div_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   alu_out_q, alu_out_d;
  logic [REG_AW-1:0]   wreg_q, wreg_d;
  logic                regwrite_q, regwrite_d;

  logic                accept_s, mdu_grp_s, mt_grp_s, mdu_op_s, mt_op_s, beat_s, sgn_s;
  logic [SH_W-1:0]     shamt_s;
  logic [DATA_W-1:0]   alu_res_s, a_mag_s, b_mag_s;
  logic [DATA_W:0]     mul_sum_s, div_sh_s;
  logic                div_ge_s;
  logic [DATA_W-1:0]   div_sub_s, quot_fix_s, rem_fix_s;
  logic [2*DATA_W-1:0] prod_fix_s;
  logic [REG_AW-1:0]   dest_s;
  logic                mov_we_s;

  assign bus.in_ready          = !busy_q && (!out_valid_q || bus.out_ready);
  assign bus.out_valid         = out_valid_q;
  assign bus.ALU_out           = alu_out_q;
  assign bus.WriteRegister_out = wreg_q;
  assign bus.RegWrite_out      = regwrite_q;
  assign bus.HI                = hi_q;
  assign bus.LO                = lo_q;
  assign bus.mdu_busy          = busy_q;

  assign accept_s  = bus.in_valid && bus.in_ready;
  assign mdu_grp_s = (bus.ALUop[4:2] == 3'b110);
  assign mt_grp_s  = (bus.ALUop[4:1] == 4'b1111);
  assign mdu_op_s  = !bus.MovEn && mdu_grp_s;
  assign mt_op_s   = !bus.MovEn && mt_grp_s;
  assign beat_s    = bus.MovEn || !(mdu_grp_s || mt_grp_s);
  assign sgn_s     = !bus.ALUop[0];
  assign a_mag_s   = mag_f(bus.Read1, sgn_s);
  assign b_mag_s   = mag_f(bus.Read2, sgn_s);
  assign shamt_s   = bus.Read1[SH_W-1:0];
  assign dest_s    = bus.regAddr_jal ? REG_AW'(LINK_REG) : (bus.RegDst ? bus.rd : bus.rt);
  assign mov_we_s  = bus.RegWrite_in | ((bus.Read2 == '0) ~^ bus.Movz);

  // One shift-add / restoring-subtract step on magnitudes per busy cycle.
  assign mul_sum_s  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : {(DATA_W+1){1'b0}});
  assign div_sh_s   = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_ge_s   = (div_sh_s >= {1'b0, opa_q});
  assign div_sub_s  = div_sh_s[DATA_W-1:0] - opa_q;
  assign prod_fix_s = neg_q ? (~{acc_hi_q, acc_lo_q} + {{(2*DATA_W-1){1'b0}}, 1'b1})
                            : {acc_hi_q, acc_lo_q};
  assign quot_fix_s = neg_q ? (~acc_lo_q + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_lo_q;
  assign rem_fix_s  = rem_neg_q ? (~acc_hi_q + {{(DATA_W-1){1'b0}}, 1'b1}) : acc_hi_q;

`ifdef FAST_MULT_EN
  logic [2*DATA_W-1:0] fast_prod_s;
  assign fast_prod_s = {{DATA_W{1'b0}}, a_mag_s} * {{DATA_W{1'b0}}, b_mag_s};
`endif

  // Integer ALU; MFHI/MFLO read the architectural registers.
  always_comb begin
    alu_res_s = '0;
    case (bus.ALUop)
      5'd0:    alu_res_s = bus.Read1 + bus.Read2;
      5'd1:    alu_res_s = bus.Read1 - bus.Read2;
      5'd2:    alu_res_s = bus.Read1 & bus.Read2;
      5'd3:    alu_res_s = bus.Read1 | bus.Read2;
      5'd4:    alu_res_s = bus.Read1 ^ bus.Read2;
      5'd5:    alu_res_s = ~(bus.Read1 | bus.Read2);
      5'd6:    alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(bus.Read1) < $signed(bus.Read2))};
      5'd7:    alu_res_s = {{(DATA_W-1){1'b0}}, (bus.Read1 < bus.Read2)};
      5'd8:    alu_res_s = bus.Read2 << shamt_s;
      5'd9:    alu_res_s = bus.Read2 >> shamt_s;
      5'd10:   alu_res_s = DATA_W'($signed(bus.Read2) >>> shamt_s);
      5'd28:   alu_res_s = hi_q;
      5'd29:   alu_res_s = lo_q;
      default: alu_res_s = '0;
    endcase
  end

  // MDU sequencing and HI/LO updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opa_d     = opa_q;
    dvd_d     = dvd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    divz_d    = divz_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (accept_s && mdu_op_s) begin
          cnt_d     = '0;
          is_div_d  = bus.ALUop[1];
          neg_d     = sgn_s && (bus.Read1[DATA_W-1] ^ bus.Read2[DATA_W-1]);
          rem_neg_d = sgn_s && bus.Read1[DATA_W-1];
          divz_d    = (bus.Read2 == '0);
          dvd_d     = bus.Read1;
          acc_hi_d  = '0;
          if (bus.ALUop[1]) begin
            acc_lo_d = a_mag_s;
            opa_d    = b_mag_s;
            state_d  = DIV;
          end else begin
`ifdef FAST_MULT_EN
            {acc_hi_d, acc_lo_d} = fast_prod_s;
            state_d              = FIX;
`else
            acc_lo_d = b_mag_s;
            opa_d    = a_mag_s;
            state_d  = MUL;
`endif
          end
        end else if (accept_s && mt_op_s) begin
          if (bus.ALUop[0]) begin
            lo_d = bus.Read1;
          end else begin
            hi_d = bus.Read1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_hi_d = mul_sum_s[DATA_W:1];
        acc_lo_d = {mul_sum_s[0], acc_lo_q[DATA_W-1:1]};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d  = (cnt_q == LAST_STEP) ? FIX : MUL;
      end
      DIV: begin
        acc_hi_d = div_ge_s ? div_sub_s : div_sh_s[DATA_W-1:0];
        acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge_s};
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        state_d  = (cnt_q == LAST_STEP) ? FIX : DIV;
      end
      FIX: begin
        if (is_div_q && divz_q) begin
          lo_d = '1;
          hi_d = dvd_q;
        end else if (is_div_q) begin
          lo_d = quot_fix_s;
          hi_d = rem_fix_s;
        end else begin
          hi_d = prod_fix_s[2*DATA_W-1:DATA_W];
          lo_d = prod_fix_s[DATA_W-1:0];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Result register: loads on a result-producing accept, holds under back-pressure.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    wreg_d      = wreg_q;
    regwrite_d  = regwrite_q;
    if (accept_s && beat_s) begin
      out_valid_d = 1'b1;
      alu_out_d   = bus.MovEn ? bus.Read1 : alu_res_s;
      wreg_d      = dest_s;
      regwrite_d  = bus.MovEn ? mov_we_s : bus.RegWrite_in;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and datapath registers; reset discards any MDU op in flight.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opa_q       <= '0;
      dvd_q       <= '0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      divz_q      <= 1'b0;
      is_div_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opa_q       <= opa_d;
      dvd_q       <= dvd_d;
      neg_q       <= neg_d;
      rem_neg_q   <= rem_neg_d;
      divz_q      <= divz_d;
      is_div_q    <= is_div_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      wreg_q      <= wreg_d;
      regwrite_q  <= regwrite_d;
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu: result beats are queued at issue and
// popped when the stage hands them to MEM; HI/LO come from an independent reference model.
module tb_execute_stage_mdu;

  logic clk = 1'b0;
  logic rst_n;

  execute_stage_mdu_if #(.DATA_W(32), .REG_AW(5)) bus_if ();

  execute_stage_mdu #(.DATA_W(32), .REG_AW(5), .LINK_REG(31)) dut (
    .Clk (clk),
    .Rst (rst_n),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    logic        we;
  } beat_t;

  beat_t       sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi, m_lo;

`ifdef FAST_MULT_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      5'd5:    return ~(a | b);
      5'd6:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd7:    return (a < b) ? 32'd1 : 32'd0;
      5'd8:    return b << a[4:0];
      5'd9:    return b >> a[4:0];
      5'd10:   return $signed(b) >>> a[4:0];
      5'd28:   return m_hi;
      5'd29:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic mdu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sbv;
    sa  = a;
    sbv = b;
    case (op)
      5'd24: begin sp = longint'(sa) * longint'(sbv); {m_hi, m_lo} = sp; end
      5'd25: begin up = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = up; end
      5'd26, 5'd27: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 5'd26 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else if (op == 5'd26) begin
          m_lo = sa / sbv;
          m_hi = sa % sbv;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      5'd30:   m_hi = a;
      5'd31:   m_lo = a;
      default: m_hi = m_hi;
    endcase
  endtask

  // Drive one issue, wait (bounded) for acceptance, record the expectation.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mov_en, input logic movz, input logic [4:0] rt_a,
                       input logic [4:0] rd_a, input logic we, input logic dst,
                       input logic jal, output int waited);
    beat_t e;
    bus_if.ALUop = op;        bus_if.Read1 = a;      bus_if.Read2 = b;
    bus_if.MovEn = mov_en;    bus_if.Movz = movz;    bus_if.rt = rt_a;
    bus_if.rd = rd_a;         bus_if.RegWrite_in = we;
    bus_if.RegDst = dst;      bus_if.regAddr_jal = jal;
    bus_if.in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!bus_if.in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    check_val("issue_accept", {63'd0, bus_if.in_ready}, 64'd1);
    if (mov_en || op <= 5'd23 || op == 5'd28 || op == 5'd29) begin
      e.res = mov_en ? a : alu_model(op, a, b);
      e.dst = jal ? 5'd31 : (dst ? rd_a : rt_a);
      e.we  = mov_en ? (we | ((b == 32'd0) ~^ movz)) : we;
      sb_q.push_back(e);
    end else begin
      mdu_model(op, a, b);
    end
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic op_r(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    issue(op, a, b, 1'b0, 1'b0, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, w);
  endtask

  task automatic busy_len(input string tag, input int exp_len);
    int n, irl;
    n = 0;
    irl = 0;
    @(negedge clk);
    while (bus_if.mdu_busy && n < 100) begin
      n++;
      if (!bus_if.in_ready) irl++;
      @(negedge clk);
    end
    check_val({tag, "_busy_len"}, n, exp_len);
    check_val({tag, "_inready_low"}, irl, exp_len);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus_if.out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("drain", sb_q.size(), 64'd0);
  endtask

  // Result monitor: a beat is taken at the next rising edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      beat_t e;
      check_val("sb_has_entry", {63'd0, (sb_q.size() != 0)}, 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check_val("beat_res", bus_if.ALU_out, e.res);
        check_val("beat_dst", bus_if.WriteRegister_out, e.dst);
        check_val("beat_we", bus_if.RegWrite_out, e.we);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] a_v, b_v;
    rst_n = 1'b0;
    bus_if.in_valid = 1'b0;  bus_if.out_ready = 1'b1;
    bus_if.Read1 = '0;       bus_if.Read2 = '0;     bus_if.ALUop = '0;
    bus_if.MovEn = 1'b0;     bus_if.Movz = 1'b0;    bus_if.rt = '0;
    bus_if.rd = '0;          bus_if.RegWrite_in = 1'b0;
    bus_if.RegDst = 1'b0;    bus_if.regAddr_jal = 1'b0;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus_if.out_valid, 64'd0);
    check_val("rst_alu_out", bus_if.ALU_out, 64'd0);
    check_val("rst_wreg", bus_if.WriteRegister_out, 64'd0);
    check_val("rst_regwrite", bus_if.RegWrite_out, 64'd0);
    check_val("rst_hi", bus_if.HI, 64'd0);
    check_val("rst_lo", bus_if.LO, 64'd0);
    check_val("rst_busy", bus_if.mdu_busy, 64'd0);
    check_val("rst_in_ready", bus_if.in_ready, 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD 7+5 to rd=9, then a sweep of ALU ops with boundary operands.
    issue(5'd0, 32'd7, 32'd5, 1'b0, 1'b0, 5'd3, 5'd9, 1'b1, 1'b1, 1'b0, w);
    for (int op = 0; op <= 11; op++) begin
      for (int k = 0; k < 3; k++) begin
        a_v = (k == 0) ? 32'hFFFF_FFFF : $urandom;
        b_v = (k == 1) ? 32'h8000_0000 : $urandom;
        issue(5'(op), a_v, b_v, 1'b0, 1'b0, 5'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom), 1'b0, w);
      end
    end
    op_r(5'd23, 32'h1234_5678, 32'h9ABC_DEF0);

    // MOVZ / MOVN qualification.
    issue(5'd0, 32'h0000_ABCD, 32'd0, 1'b1, 1'b1, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, w);
    issue(5'd0, 32'h0000_ABCD, 32'd3, 1'b1, 1'b1, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, w);
    issue(5'd0, 32'h0000_ABCD, 32'd3, 1'b1, 1'b0, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, w);
    issue(5'd0, 32'h0000_ABCD, 32'd0, 1'b1, 1'b0, 5'd4, 5'd6, 1'b0, 1'b1, 1'b0, w);

    // Multiply: signed and unsigned, latency and HI/LO.
    op_r(5'd24, 32'hFFFF_FFFF, 32'd2);
    busy_len("mult", MUL_BUSY);
    check_val("mult_hi", bus_if.HI, 64'hFFFF_FFFF);
    check_val("mult_lo", bus_if.LO, 64'hFFFF_FFFE);
    op_r(5'd28, 32'd0, 32'd0);
    op_r(5'd29, 32'd0, 32'd0);
    op_r(5'd25, 32'hFFFF_FFFF, 32'd2);
    busy_len("multu", MUL_BUSY);
    check_val("multu_hi", bus_if.HI, 64'd1);
    for (int k = 0; k < 3; k++) begin
      op_r((k == 1) ? 5'd25 : 5'd24, $urandom, $urandom);
      op_r(5'd28, 32'd0, 32'd0);
      op_r(5'd29, 32'd0, 32'd0);
    end

    // Divide: signed truncation, divide by zero, MIN/-1.
    op_r(5'd26, 32'hFFFF_FFF9, 32'd2);
    busy_len("div", 33);
    check_val("div_lo", bus_if.LO, 64'hFFFF_FFFD);
    check_val("div_hi", bus_if.HI, 64'hFFFF_FFFF);
    op_r(5'd27, 32'd5, 32'd0);
    busy_len("divu0", 33);
    check_val("divu0_lo", bus_if.LO, 64'hFFFF_FFFF);
    check_val("divu0_hi", bus_if.HI, 64'd5);
    op_r(5'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    op_r(5'd29, 32'd0, 32'd0);
    op_r(5'd28, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      op_r((k < 2) ? 5'd26 : 5'd27, $urandom, (k == 3) ? 32'd0 : ($urandom >> (k * 8)));
      op_r(5'd28, 32'd0, 32'd0);
      op_r(5'd29, 32'd0, 32'd0);
    end

    // MTHI/MTLO, including one accepted right behind a pending beat.
    op_r(5'd0, 32'd1, 32'd1);
    op_r(5'd30, 32'hCAFE_0001, 32'd0);
    op_r(5'd31, 32'hBEEF_0002, 32'd0);
    op_r(5'd28, 32'd0, 32'd0);
    op_r(5'd29, 32'd0, 32'd0);

    // Back-pressure: result held for three cycles, then released with a same-cycle issue.
    drain();
    bus_if.out_ready = 1'b0;
    issue(5'd0, 32'd100, 32'd23, 1'b0, 1'b0, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, w);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("stall_valid", bus_if.out_valid, 64'd1);
      check_val("stall_alu", bus_if.ALU_out, 64'd123);
      check_val("stall_dst", bus_if.WriteRegister_out, 64'd13);
      check_val("stall_in_ready", bus_if.in_ready, 64'd0);
    end
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b1;
    issue(5'd1, 32'd50, 32'd8, 1'b0, 1'b0, 5'd14, 5'd15, 1'b1, 1'b0, 1'b0, w);
    check_val("stall_release_wait", w, 64'd0);
    drain();

    // Asynchronous reset in the middle of a divide.
    op_r(5'd26, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_busy", bus_if.mdu_busy, 64'd0);
    check_val("arst_hi", bus_if.HI, 64'd0);
    check_val("arst_lo", bus_if.LO, 64'd0);
    check_val("arst_out_valid", bus_if.out_valid, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op_r(5'd28, 32'd0, 32'd0);
    issue(5'd0, 32'd1, 32'd2, 1'b0, 1'b0, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, w);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
